// File: rtl/sd_spi_cmd_engine_if.sv
// rtl/sd_spi_cmd_engine_if.sv - byte-level SPI exchange handshake between the command engine and spi_controller
interface sd_spi_cmd_engine_if;
  logic       cs;
  logic       txrx_start;
  logic [7:0] tx_byte;
  logic [7:0] rx_byte;
  logic       txrx_done;

  modport master (output cs, output txrx_start, output tx_byte, input rx_byte, input txrx_done);
  modport slave  (input cs, input txrx_start, input tx_byte, output rx_byte, output txrx_done);
endinterface

// File: rtl/sd_spi_cmd_engine.sv
// rtl/sd_spi_cmd_engine.sv - SD-over-SPI command framing, R1 polling and response capture
// Optional SD_CRC7_GEN_EN: generate CRC7 over the 40 header bits instead of using i_cmd_crc.
module sd_spi_cmd_engine #(
  parameter int NCR_MAX        = 8,
  parameter int MAX_RESP_BYTES = 5,
  parameter int POST_BYTES     = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_start,
  input  logic [5:0]                  i_cmd_index,
  input  logic [31:0]                 i_cmd_arg,
  input  logic [6:0]                  i_cmd_crc,
  input  logic [3:0]                  i_resp_extra,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_timeout,
  output logic [8*MAX_RESP_BYTES-1:0] o_resp_data,
  sd_spi_cmd_engine_if.master         spi
);

  localparam int POLLW    = $clog2(NCR_MAX + 1);
  localparam int RW       = $clog2(MAX_RESP_BYTES + 1);
  localparam int PW       = (POST_BYTES > 0) ? $clog2(POST_BYTES + 1) : 1;
  localparam int MAX_XTRA = MAX_RESP_BYTES - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SEND, S_POLL, S_RESP, S_END, S_POST, S_FIN
  } state_t;

  state_t                      r_state, w_next;
  logic                        r_inflight, r_txrx_start, r_cs, r_busy, r_timeout;
  logic [7:0]                  r_tx_byte;
  logic [5:0]                  r_idx;
  logic [31:0]                 r_arg;
  logic [6:0]                  r_crc;
  logic [RW-1:0]               r_extra, r_resp_cnt;
  logic [2:0]                  r_byte_cnt;
  logic [POLLW-1:0]            r_poll_cnt;
  logic [PW-1:0]               r_post_cnt;
  logic [8*MAX_RESP_BYTES-1:0] r_resp_data;
  logic                        w_issue, w_xdone, w_crc_ready;
  logic [7:0]                  w_tx, w_frame_byte;

  assign w_xdone         = r_inflight & spi.txrx_done;
  assign spi.cs          = r_cs;
  assign spi.txrx_start  = r_txrx_start;
  assign spi.tx_byte     = r_tx_byte;
  assign o_busy          = r_busy;
  assign o_done          = (r_state == S_FIN);
  assign o_timeout       = r_timeout;
  assign o_resp_data     = r_resp_data;

`ifdef SD_CRC7_GEN_EN
  logic [5:0]  r_crc_cnt;
  logic        r_crc_busy;
  logic [39:0] w_hdr;
  logic        w_fb;

  assign w_hdr       = {2'b01, r_idx, r_arg};
  assign w_fb        = w_hdr[6'd39 - r_crc_cnt] ^ r_crc[6];
  assign w_crc_ready = ~r_crc_busy;

  // Serial CRC7 (x^7+x^3+1), one header bit per clock, starting the cycle after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc      <= '0;
      r_crc_cnt  <= '0;
      r_crc_busy <= 1'b0;
    end else if (r_state == S_IDLE && i_start) begin
      r_crc      <= '0;
      r_crc_cnt  <= '0;
      r_crc_busy <= 1'b1;
    end else if (r_crc_busy) begin
      r_crc     <= {r_crc[5:0], 1'b0} ^ (w_fb ? 7'h09 : 7'h00);
      r_crc_cnt <= r_crc_cnt + 6'd1;
      if (r_crc_cnt == 6'd39) r_crc_busy <= 1'b0;
    end
  end
`else
  assign w_crc_ready = 1'b1;
`endif

  always_comb begin
    w_frame_byte = 8'hFF;
    case (r_byte_cnt)
      3'd0:    w_frame_byte = {2'b01, r_idx};
      3'd1:    w_frame_byte = r_arg[31:24];
      3'd2:    w_frame_byte = r_arg[23:16];
      3'd3:    w_frame_byte = r_arg[15:8];
      3'd4:    w_frame_byte = r_arg[7:0];
      3'd5:    w_frame_byte = {r_crc, 1'b1};
      default: w_frame_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Exchange-carrying states issue one byte when nothing is in flight and advance on txrx_done.
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_tx    = 8'hFF;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_PRE;
      S_PRE: begin
        w_issue = ~r_inflight & w_crc_ready;
        if (w_xdone) w_next = S_SEND;
      end
      S_SEND: begin
        w_issue = ~r_inflight;
        w_tx    = w_frame_byte;
        if (w_xdone && r_byte_cnt == 3'd5) w_next = S_POLL;
      end
      S_POLL: begin
        w_issue = ~r_inflight;
        if (w_xdone) begin
          if (!spi.rx_byte[7])
            w_next = (r_extra != '0) ? S_RESP : S_END;
          else if (r_poll_cnt == POLLW'(NCR_MAX - 1))
            w_next = S_END;
        end
      end
      S_RESP: begin
        w_issue = ~r_inflight;
        if (w_xdone && r_resp_cnt == r_extra - RW'(1)) w_next = S_END;
      end
      S_END:  w_next = (POST_BYTES > 0) ? S_POST : S_FIN;
      S_POST: begin
        w_issue = ~r_inflight;
        if (w_xdone && r_post_cnt == PW'(POST_BYTES - 1)) w_next = S_FIN;
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight   <= 1'b0;
      r_txrx_start <= 1'b0;
      r_tx_byte    <= 8'hFF;
      r_cs         <= 1'b1;
      r_busy       <= 1'b0;
      r_timeout    <= 1'b0;
      r_resp_data  <= '0;
      r_idx        <= '0;
      r_arg        <= '0;
      r_extra      <= '0;
      r_byte_cnt   <= '0;
      r_poll_cnt   <= '0;
      r_resp_cnt   <= '0;
      r_post_cnt   <= '0;
`ifndef SD_CRC7_GEN_EN
      r_crc        <= '0;
`endif
    end else begin
      r_txrx_start <= w_issue;
      if (w_issue) begin
        r_tx_byte  <= w_tx;
        r_inflight <= 1'b1;
      end
      if (w_xdone) r_inflight <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_idx       <= i_cmd_index;
          r_arg       <= i_cmd_arg;
`ifndef SD_CRC7_GEN_EN
          r_crc       <= i_cmd_crc;
`endif
          r_extra     <= (int'(i_resp_extra) > MAX_XTRA) ? RW'(MAX_XTRA) : RW'(i_resp_extra);
          r_cs        <= 1'b0;
          r_busy      <= 1'b1;
          r_resp_data <= '0;
          r_timeout   <= 1'b0;
          r_byte_cnt  <= '0;
          r_poll_cnt  <= '0;
          r_resp_cnt  <= '0;
          r_post_cnt  <= '0;
        end
        S_SEND: if (w_xdone) r_byte_cnt <= r_byte_cnt + 3'd1;
        S_POLL: if (w_xdone) begin
          if (!spi.rx_byte[7]) begin
            r_resp_data[8*MAX_RESP_BYTES-1 -: 8] <= spi.rx_byte;
          end else begin
            r_poll_cnt <= r_poll_cnt + POLLW'(1);
            if (r_poll_cnt == POLLW'(NCR_MAX - 1)) r_timeout <= 1'b1;
          end
        end
        S_RESP: if (w_xdone) begin
          // Extras fill downward from just below R1.
          for (int i = 1; i < MAX_RESP_BYTES; i++)
            if (i == int'(r_resp_cnt) + 1)
              r_resp_data[8*(MAX_RESP_BYTES-1-i) +: 8] <= spi.rx_byte;
          r_resp_cnt <= r_resp_cnt + RW'(1);
        end
        S_END:  r_cs <= 1'b1;
        S_POST: if (w_xdone) r_post_cnt <= r_post_cnt + PW'(1);
        S_FIN:  r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// tb/tb_sd_spi_cmd_engine.sv - directed self-checking bench for sd_spi_cmd_engine with a scripted SPI byte responder
module tb_sd_spi_cmd_engine;
  localparam int NCR = 8;
  localparam int MRB = 5;
  localparam int PB  = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic [5:0]        i_cmd_index = '0;
  logic [31:0]       i_cmd_arg = '0;
  logic [6:0]        i_cmd_crc = '0;
  logic [3:0]        i_resp_extra = '0;
  logic              o_busy, o_done, o_timeout;
  logic [8*MRB-1:0]  o_resp_data;

  sd_spi_cmd_engine_if ifc ();

  sd_spi_cmd_engine #(.NCR_MAX(NCR), .MAX_RESP_BYTES(MRB), .POST_BYTES(PB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_cmd_index  (i_cmd_index),
    .i_cmd_arg    (i_cmd_arg),
    .i_cmd_crc    (i_cmd_crc),
    .i_resp_extra (i_resp_extra),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_timeout    (o_timeout),
    .o_resp_data  (o_resp_data),
    .spi          (ifc)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] script [256];
  logic [7:0] tx_log [256];
  logic       cs_log [256];
  int         ex_cnt = 0;
  int         done_cnt;
  logic       done_seen;
  logic       to_at_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte-exchange responder: answers each txrx_start two cycles later with the scripted byte.
  initial begin
    int pend;
    int cur;
    pend = 0;
    cur  = 0;
    ifc.rx_byte   = 8'hFF;
    ifc.txrx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ifc.txrx_done = 1'b0;
      ifc.rx_byte   = 8'hFF;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          ifc.txrx_done = 1'b1;
          ifc.rx_byte   = script[cur];
        end
      end
      if (ifc.txrx_start && ex_cnt < 256) begin
        tx_log[ex_cnt] = ifc.tx_byte;
        cs_log[ex_cnt] = ifc.cs;
        cur  = ex_cnt;
        ex_cnt++;
        pend = 2;
      end
    end
  end

  task automatic pulse_start(input logic [5:0] idx, input logic [31:0] arg,
                             input logic [6:0] crc, input logic [3:0] extra);
    @(negedge clk);
    i_cmd_index  = idx;
    i_cmd_arg    = arg;
    i_cmd_crc    = crc;
    i_resp_extra = extra;
    i_start      = 1'b1;
    @(negedge clk);
    i_start      = 1'b0;
    i_cmd_index  = 6'h3F;
    i_cmd_arg    = 32'hDEADBEEF;
    i_resp_extra = 4'd0;
  endtask

  task automatic wait_done(input string tag);
    done_cnt  = 0;
    done_seen = 1'b0;
    for (int c = 0; c < 1500 && !done_seen; c++) begin
      @(posedge clk);
      #1;
      if (o_done) begin
        done_cnt++;
        done_seen  = 1'b1;
        to_at_done = o_timeout;
      end
    end
    check({tag, "_done_seen"}, done_seen, 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (o_done) done_cnt++;
    end
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_busy_after"}, o_busy, 1'b0);
  endtask

  initial begin
    int base;
    logic [7:0] exp_cmd0 [10];
    exp_cmd0 = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF, 8'hFF};
    for (int i = 0; i < 256; i++) script[i] = 8'hFF;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_timeout", o_timeout, 1'b0);
    check("rst_resp", o_resp_data, '0);
    check("rst_cs", ifc.cs, 1'b1);
    check("rst_txrx_start", ifc.txrx_start, 1'b0);
    check("rst_tx_byte", ifc.tx_byte, 8'hFF);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // CMD0: R1 = 0x01 on the second poll
    base = ex_cnt;
    script[base + 8] = 8'h01;
    pulse_start(6'd0, 32'h0, 7'h4A, 4'd0);
    check("cmd0_busy", o_busy, 1'b1);
    wait_done("cmd0");
    check("cmd0_xcount", ex_cnt - base, 10);
    for (int k = 0; k < 10; k++)
      check($sformatf("cmd0_tx%0d", k), tx_log[base + k], exp_cmd0[k]);
    check("cmd0_cs_poll", cs_log[base + 8], 1'b0);
    check("cmd0_cs_post", cs_log[base + 9], 1'b1);
    check("cmd0_resp", o_resp_data, 40'h01_0000_0000);
    check("cmd0_timeout", to_at_done, 1'b0);
    check("cmd0_cs_idle", ifc.cs, 1'b1);

    // CMD8 with four trailing bytes
    base = ex_cnt;
    script[base + 7]  = 8'h01;
    script[base + 8]  = 8'h00;
    script[base + 9]  = 8'h00;
    script[base + 10] = 8'h01;
    script[base + 11] = 8'hAA;
    pulse_start(6'd8, 32'h0000_01AA, 7'h43, 4'd4);
    wait_done("cmd8");
    check("cmd8_xcount", ex_cnt - base, 13);
    check("cmd8_tx_hdr", tx_log[base + 1], 8'h48);
    check("cmd8_tx_arg", tx_log[base + 5], 8'hAA);
    check("cmd8_tx_crc", tx_log[base + 6], 8'h87);
    check("cmd8_resp", o_resp_data, 40'h01_0000_01AA);
    check("cmd8_timeout", to_at_done, 1'b0);

    // No response: NCR_MAX polls then timeout
    base = ex_cnt;
    pulse_start(6'd1, 32'h0, 7'h7C, 4'd2);
    wait_done("tmo");
    check("tmo_xcount", ex_cnt - base, 8 + NCR);
    check("tmo_flag", to_at_done, 1'b1);
    check("tmo_flag_hold", o_timeout, 1'b1);
    check("tmo_resp", o_resp_data, '0);
    check("tmo_cs_last_poll", cs_log[base + 14], 1'b0);
    check("tmo_cs_post", cs_log[base + 15], 1'b1);
    check("tmo_cs", ifc.cs, 1'b1);

    // Start while busy is ignored
    base = ex_cnt;
    script[base + 7] = 8'h01;
    pulse_start(6'd0, 32'h0, 7'h4A, 4'd0);
    for (int c = 0; c < 200 && ex_cnt < base + 3; c++) begin
      @(posedge clk);
      #1;
    end
    check("ign_busy", o_busy, 1'b1);
    check("ign_timeout_cleared", o_timeout, 1'b0);
    pulse_start(6'd5, 32'h1111_2222, 7'h11, 4'd3);
    wait_done("ign");
    check("ign_xcount", ex_cnt - base, 9);
    check("ign_tx_hdr", tx_log[base + 1], 8'h40);
    check("ign_tx_arg", tx_log[base + 4], 8'h00);
    check("ign_tx_crc", tx_log[base + 6], 8'h95);
    check("ign_resp", o_resp_data, 40'h01_0000_0000);

    // Reset during frame byte 3
    base = ex_cnt;
    pulse_start(6'd17, 32'h1234_5678, 7'h2B, 4'd0);
    for (int c = 0; c < 200 && ex_cnt < base + 5; c++) begin
      @(posedge clk);
      #1;
    end
    check("rsm_reached_b3", tx_log[base + 4], 8'h56);
    #2;
    rst_n = 1'b0;
    #1;
    check("rsm_cs", ifc.cs, 1'b1);
    check("rsm_busy", o_busy, 1'b0);
    check("rsm_txrx_start", ifc.txrx_start, 1'b0);
    check("rsm_tx_byte", ifc.tx_byte, 8'hFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rsm_idle_busy", o_busy, 1'b0);
    check("rsm_no_exchange", ex_cnt - base, 5);
    base = ex_cnt;
    script[base + 7] = 8'h01;
    pulse_start(6'd0, 32'h0, 7'h4A, 4'd0);
    wait_done("rsm2");
    check("rsm2_xcount", ex_cnt - base, 9);
    for (int k = 0; k < 7; k++)
      check($sformatf("rsm2_tx%0d", k), tx_log[base + k], exp_cmd0[k]);

    // resp_extra clamped to MAX_RESP_BYTES-1
    base = ex_cnt;
    script[base + 7]  = 8'h01;
    script[base + 8]  = 8'h11;
    script[base + 9]  = 8'h22;
    script[base + 10] = 8'h33;
    script[base + 11] = 8'h44;
    script[base + 12] = 8'h55;
    pulse_start(6'd58, 32'h0, 7'h7E, 4'd15);
    wait_done("clamp");
    check("clamp_xcount", ex_cnt - base, 13);
    check("clamp_resp", o_resp_data, 40'h01_1122_3344);
    check("clamp_cs_resp", cs_log[base + 11], 1'b0);
    check("clamp_cs_post", cs_log[base + 12], 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
